// File: rtl/vcd_change_logger.sv
// rtl/vcd_change_logger.sv - value-change logger: timestamps bus changes into a drainable FIFO
module vcd_change_logger #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TS_W-1:0]   out_ts,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic [7:0]        drop_cnt,
  input  logic              clr_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]        ts_q;
  logic [DATA_W-1:0]      prev_q;
  logic [TS_W+DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [CW-1:0]          count_q;

  logic change;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign change = en && (din != prev_q);
  assign pop    = out_valid && out_ready;
  assign full   = (count_q == CW'(DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q     <= '0;
      prev_q   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (en) begin
        ts_q   <= ts_q + 1'b1;
        prev_q <= din;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A drop on the same edge as a clear takes priority.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)               drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ts_q, din};
  end

  assign out_valid         = (count_q != '0);
  assign count             = count_q;
  assign {out_ts, out_data} = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/vcd_change_logger.md
Name: vcd_change_logger

Overview:
- Downstream consumer of the registered 8-bit output of the DUT register stage.
- Samples the bus every clock and detects value changes.
- Stamps each change with a free-running cycle timestamp and buffers {timestamp, value} records in a small FIFO.
- Records drain to the waveform-dump side over a valid/ready interface; effectively an on-chip value-change-dump source.

Parameters:
- DATA_W, 8, width of monitored bus.
- TS_W, 16, timestamp counter width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CW, $clog2(DEPTH)+1, occupancy count width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  capture enable; timestamp and change detection advance only when high.
- din  in  DATA_W  monitored bus (DUT register output).
- out_valid  out  1  FIFO head record valid.
- out_ready  in  1  consumer accepts head record.
- out_data  out  DATA_W  head record value.
- out_ts  out  TS_W  head record timestamp.
- count  out  CW  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one change dropped.
- drop_cnt  out  8  dropped-record count, saturates at 255.
- clr_ovf  in  1  clears overflow and drop_cnt.

Behaviour:
- Async reset (rstn=0):
  - ts_q=0, prev_q=0, FIFO empty (rd/wr pointers 0).
  - count=0, out_valid=0, overflow=0, drop_cnt=0.
  - out_data/out_ts=0 while empty.
  - Reset mid-operation discards all buffered records immediately.
- Timestamp: at each edge with en=1, ts_q <= ts_q+1, modulo 2^TS_W (wraps 0xFFFF->0 silently). Holds when en=0.
- Change detect, at each edge with en=1:
  - change = (din != prev_q).
  - prev_q <= din.
  - When en=0, prev_q holds and no records are produced.
- Record: on change, push {ts_q (pre-increment value), din}. Record is visible at the FIFO head no earlier than the cycle after that edge (1-cycle latency when empty).
- FIFO:
  - out_valid = (count != 0).
  - out_data/out_ts driven from head storage, no extra register stage.
  - Pop when out_valid && out_ready; head advances at that edge.
  - ready with no valid: ignored.
  - Pointers wrap modulo DEPTH; count is the true occupancy.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - This also holds when full: the pop frees the slot and the push is accepted.
  - When empty with push: no pop (out_valid was 0).
- Full, push, no pop:
  - Record dropped; FIFO contents unchanged.
  - overflow <= 1; drop_cnt <= drop_cnt+1, saturating at 255.
- clr_ovf=1 at an edge: overflow<=0, drop_cnt<=0. If a drop occurs on the same edge, the drop wins: overflow=1, drop_cnt=1.
- Consumer stall: out_data/out_ts stable while out_valid && !out_ready.
- Latency: a din change sampled at edge k with an empty FIFO gives out_valid=1 in cycle k+1.

Test Plan:
- Reset/idle:
  - Stimulus: rstn=0 for 2 cycles, then en=1, din=0, out_ready=0, for 10 cycles.
  - Required: out_valid=0, count=0, overflow=0; ts_q reaches 10.
- Single changes:
  - Stimulus: en=1 from reset; din=0x0F sampled at ts=1, din=0x0A sampled at ts=3; out_ready=1.
  - Required: records (ts=1, 0x0F) then (ts=3, 0x0A), each out_valid one cycle after its sample edge; no record for unchanged cycles.
- Backpressure/full/overflow:
  - Stimulus: out_ready=0; din toggles 0x00/0xFF every cycle for 10 edges.
  - Required: count=8 with 8 records held; overflow=1, drop_cnt=2.
  - Then: drain with out_ready=1.
  - Required: records emerge in order with consecutive timestamps; clr_ovf pulse gives overflow=0, drop_cnt=0.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full (count=8), out_ready=1 on the same edge as a change.
  - Required: count stays 8, no drop, and the new record appears last.
- Enable gating and wrap:
  - Stimulus: en=0 while din changes 0x11->0x22.
  - Required: no record; ts frozen.
  - Stimulus: preload ts near 0xFFFF (run 65535 cycles), then a change at ts=0xFFFF and another after wrap.
  - Required: records carry out_ts=0xFFFF and 0x0000.
- Reset mid-operation:
  - Stimulus: 3 records buffered, overflow=1; assert rstn=0 asynchronously between edges.
  - Required: out_valid, count, overflow and drop_cnt drop to 0 immediately; after release, the first change carries a ts counted from 0.
